// File: rtl/imem_boot_loader.sv
// Boot loader that turns a byte stream (16-bit LE word count, then LE words) into IMEM writes, holding the core in reset until the image is in.
// Optional build macro IMEM_BOOT_CHECKSUM_EN adds a trailing checksum byte verified against an 8-bit sum of the data bytes.
module imem_boot_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR   = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;
`ifdef IMEM_BOOT_CHECKSUM_EN
  localparam logic [2:0] S_CHK   = 3'd6;
`endif

  // Word count is 16 bits, so a 17-bit compare covers capacities up to 2^16 words.
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

  logic [2:0]        state;
  logic [1:0]        bcnt;
  logic [15:0]       cnt;
  logic [ADDR_W-1:0] idx;
  logic              accept;
  logic [15:0]       hdr_n;
  logic              last_word;

`ifdef IMEM_BOOT_CHECKSUM_EN
  logic [7:0] sum;
  logic [7:0] chk_total;
  assign chk_total = sum + byte_data;
  assign byte_ready = (state == S_HDR) || (state == S_DATA) || (state == S_CHK);
`else
  assign byte_ready = (state == S_HDR) || (state == S_DATA);
`endif

  assign accept     = byte_valid && byte_ready;
  assign hdr_n      = {byte_data, cnt[7:0]};
  assign last_word  = (17'(idx) + 17'd1) == {1'b0, cnt};
  assign imem_we    = (state == S_WRITE);
  assign imem_waddr = idx;

  // NOTE: every register here is updated with non-blocking assignments so all
  // of them see pre-edge values of each other, whatever order the statements run in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      bcnt       <= 2'd0;
      cnt        <= 16'd0;
      idx        <= '0;
      imem_wdata <= 32'd0;
      core_rst_n <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
`ifdef IMEM_BOOT_CHECKSUM_EN
      sum        <= 8'd0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state      <= S_HDR;
            busy       <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            core_rst_n <= 1'b0;
            bcnt       <= 2'd0;
            idx        <= '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
            sum        <= 8'd0;
`endif
          end
        end

        S_HDR: begin
          if (accept) begin
            if (bcnt == 2'd0) begin
              cnt[7:0] <= byte_data;
              bcnt     <= 2'd1;
            end else begin
              cnt[15:8] <= byte_data;
              bcnt      <= 2'd0;
              idx       <= '0;
              if (hdr_n == 16'd0) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
                state <= S_CHK;
`else
                state      <= S_DONE;
                done       <= 1'b1;
                busy       <= 1'b0;
                core_rst_n <= 1'b1;
`endif
              end else if ({1'b0, hdr_n} > MAX_WORDS) begin
                state <= S_ERR;
                err   <= 1'b1;
                busy  <= 1'b0;
              end else begin
                state <= S_DATA;
              end
            end
          end
        end

        S_DATA: begin
          if (accept) begin
            imem_wdata[{bcnt, 3'b000} +: 8] <= byte_data;
            bcnt <= bcnt + 2'd1;
`ifdef IMEM_BOOT_CHECKSUM_EN
            sum  <= sum + byte_data;
`endif
            if (bcnt == 2'd3) state <= S_WRITE;
          end
        end

        S_WRITE: begin
          if (last_word) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
            state <= S_CHK;
`else
            state      <= S_DONE;
            done       <= 1'b1;
            busy       <= 1'b0;
            core_rst_n <= 1'b1;
`endif
          end else begin
            idx   <= idx + 1'b1;
            state <= S_DATA;
          end
        end

`ifdef IMEM_BOOT_CHECKSUM_EN
        S_CHK: begin
          if (accept) begin
            busy <= 1'b0;
            if (chk_total == 8'h00) begin
              state      <= S_DONE;
              done       <= 1'b1;
              core_rst_n <= 1'b1;
            end else begin
              state <= S_ERR;
              err   <= 1'b1;
            end
          end
        end
`endif

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: a driver streams random images and queues expected writes/outcomes; a monitor checks them.
module tb_imem_boot_loader;
  localparam int AW  = 4;
  localparam int CAP = 1 << AW;

  logic          clk, rst_n, start, byte_valid, byte_ready, imem_we;
  logic [7:0]    byte_data;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic          core_rst_n, busy, done, err;

  imem_boot_loader #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .imem_we(imem_we),
    .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .core_rst_n(core_rst_n),
    .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] addr; logic [31:0] data; } wr_t;
  typedef struct { bit ok; bit timed; } out_t;

  wr_t         wr_q[$];
  out_t        out_q[$];
  logic [31:0] img[$];
  bit          rnd_valid;
  int          checks, failures;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compares every write strobe and every end of load against the queues.
  initial begin : monitor
    int   cyc, last_we;
    bit   prev_busy;
    wr_t  w;
    out_t o;
    cyc = 0; last_we = -10; prev_busy = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        prev_busy = 0;
        continue;
      end
      if (imem_we) begin
        check("ready_low_in_write", byte_ready, 0);
        last_we = cyc;
        if (wr_q.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          w = wr_q.pop_front();
          check("write_addr", imem_waddr, w.addr);
          check("write_data", imem_wdata, w.data);
        end
      end
      if (prev_busy && !busy) begin
        if (out_q.size() == 0) begin
          check("unexpected_end", 1, 0);
        end else begin
          o = out_q.pop_front();
          check("end_done", done, o.ok);
          check("end_err", err, !o.ok);
          check("end_core_rst_n", core_rst_n, o.ok);
          check("writes_missing", wr_q.size(), 0);
          if (o.timed) check("done_latency", cyc, last_we + 1);
        end
      end
      prev_busy = busy;
    end
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit sent;
    sent = 0;
    for (int t = 0; t < 200 && !sent; t++) begin
      @(negedge clk);
      if (rnd_valid && !byte_valid && $urandom_range(1, 0) == 0) begin
        byte_valid = 1'b0;
      end else begin
        byte_valid = 1'b1;
        byte_data  = b;
        if (byte_ready) begin
          @(posedge clk);
          #1 byte_valid = 1'b0;
          sent = 1;
        end
      end
    end
    if (!sent) begin
      byte_valid = 1'b0;
      check("byte_accept_timeout", 0, 1);
    end
  endtask

  // Reference model: expected writes and outcome computed straight from the image format.
  task automatic run_image(input int n, input bit bad, input bit midstart);
    logic [7:0] bytes[$];
    logic [7:0] sum;
    wr_t        w;
    out_t       o;
    bit         was_done;
    int         t;
    sum = 8'd0;
    bytes.push_back(8'(n));
    bytes.push_back(8'(n >> 8));
    if (n <= CAP) begin
      for (int i = 0; i < n; i++) begin
        for (int k = 0; k < 4; k++) begin
          bytes.push_back(8'(img[i] >> (8 * k)));
          sum = sum + 8'(img[i] >> (8 * k));
        end
        w.addr = AW'(i);
        w.data = img[i];
        wr_q.push_back(w);
      end
    end
`ifdef IMEM_BOOT_CHECKSUM_EN
    if (n <= CAP) bytes.push_back(bad ? 8'h01 - sum : 8'h00 - sum);
    o.ok    = (n <= CAP) && !bad;
    o.timed = 0;
`else
    o.ok    = (n <= CAP);
    o.timed = (n > 0) && (n <= CAP);
`endif
    out_q.push_back(o);
    was_done = done;
    pulse_start();
    if (was_done) begin
      check("restart_core_rst_n", core_rst_n, 0);
      check("restart_busy", busy, 1);
      check("restart_done", done, 0);
    end
    foreach (bytes[k]) begin
      if (midstart && k == 3) pulse_start();
      send_byte(bytes[k]);
    end
    t = 0;
    while (out_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("load_completion", out_q.size(), 0);
    out_q.delete();
    wr_q.delete();
    @(negedge clk);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    checks = 0; failures = 0;
    rst_n = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00; rnd_valid = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_outputs",
            {byte_ready, imem_we, imem_waddr, imem_wdata, core_rst_n, busy, done, err}, 0);
    end

    // Directed two-word image, valid held, then with random valid gaps.
    img = {32'h00100513, 32'h0000006F};
    run_image(2, 0, 0);
    @(negedge clk); byte_valid = 1'b1; byte_data = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_extra_bytes", byte_ready, 0);
    end
    byte_valid = 1'b0;
    rnd_valid = 1;
    run_image(2, 0, 0);
    rnd_valid = 0;

    // Oversized image aborts; empty image completes.
    run_image(CAP + 1, 0, 0);
    run_image(0, 0, 0);

    // Mid-load start ignored, then restart from DONE overwrites addr 0.
    img = {$urandom, $urandom, $urandom};
    run_image(3, 0, 1);
    img = {32'hDEADBEEF};
    run_image(1, 0, 0);

`ifdef IMEM_BOOT_CHECKSUM_EN
    img = {32'h04030201};
    run_image(1, 0, 0);
    run_image(1, 1, 0);
`endif

    // Random images including full capacity.
    for (int r = 0; r < 8; r++) begin
      n = (r == 0) ? CAP : int'($urandom_range(CAP, 1));
      img.delete();
      for (int i = 0; i < n; i++) img.push_back($urandom);
      rnd_valid = 1'($urandom_range(1, 0));
      run_image(n, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
    end
    rnd_valid = 0;

    // Reset in the middle of a word: no write, everything back to idle.
    pulse_start();
    send_byte(8'h04);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midload_reset_outputs",
          {byte_ready, imem_we, imem_waddr, imem_wdata, core_rst_n, busy, done, err}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    img = {32'hCAFEF00D, 32'h12345678};
    run_image(2, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Writer side of the instruction memory: receives a program image as a byte stream and assembles little-endian 32-bit words.
- Writes the words into the IMEM write port while holding the core in reset; releases the core once the load completes.
- Sits between a byte source (UART RX or debug port) and the IMEM write port plus core reset at the SoC top.

Parameters:
- ADDR_W, 10, IMEM word-address width; capacity = 2^ADDR_W words.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a load
- byte_valid  in  1  source has a byte on byte_data
- byte_data  in  8  stream byte
- byte_ready  out  1  loader accepts byte this cycle
- imem_we  out  1  IMEM write strobe, one cycle per word
- imem_waddr  out  ADDR_W  IMEM word address
- imem_wdata  out  32  IMEM write data
- core_rst_n  out  1  active-low reset to CPU core
- busy  out  1  load in progress
- done  out  1  image loaded, core released
- err  out  1  load aborted

Behaviour:
- Clocking and reset:
  - All state on posedge clk; rst_n clears asynchronously.
  - Reset values: byte_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0, core_rst_n=0, busy=0, done=0, err=0; state=IDLE.
- Handshake:
  - A byte transfers when byte_valid && byte_ready.
  - byte_ready is a function of registered state only: 1 in HDR, DATA, CHK; 0 elsewhere.
  - The source must hold byte_data stable while byte_valid=1 and byte_ready=0.
- Image format:
  - 2-byte little-endian word count N.
  - Then N words, each 4 bytes, LSB first.
- States:
  - IDLE: start -> HDR, busy=1.
  - HDR: accept 2 bytes into cnt[15:0]. After byte 2:
    - N==0 -> DONE (or CHK with CHECKSUM_EN).
    - N>2^ADDR_W -> ERR.
    - otherwise -> DATA, word index idx=0.
  - DATA: accept 4 bytes; byte k goes to bits [8k+7:8k] of the word register. After byte 4 -> WRITE.
  - WRITE: imem_we=1 for exactly one cycle with imem_waddr=idx[ADDR_W-1:0] and imem_wdata=assembled word. Next:
    - idx==N-1 -> DONE (or CHK).
    - else idx+1, -> DATA.
  - DONE: done=1, busy=0, core_rst_n=1. All three change in the same cycle the state is entered.
  - ERR: err=1, busy=0, core_rst_n stays 0.
- Latency:
  - imem_we is asserted in the cycle after the 4th byte of a word is accepted.
  - done/core_rst_n assert in the cycle after the last WRITE cycle.
- core_rst_n:
  - 0 from reset until the first DONE.
  - Goes 0 in the cycle after a start accepted from DONE or ERR.
- start handling:
  - Ignored in HDR, DATA, WRITE, CHK.
  - In DONE or ERR: restarts the load, clears done/err, idx=0.
- Byte counter wraps 0..3 per word. idx never exceeds N-1; a word count of exactly 2^ADDR_W writes addresses 0..2^ADDR_W-1.
- Extra bytes after the image are not accepted (byte_ready=0 in DONE/ERR/IDLE).
- rst_n assertion mid-load aborts immediately. No partial write is completed; core_rst_n=0.

Optional Feature:
- Macro: IMEM_BOOT_CHECKSUM_EN.
- When defined:
  - An 8-bit running sum (mod 256) is kept of all data-word bytes; header bytes are excluded.
  - After the last word (or after the header if N==0) the FSM enters CHK and accepts one checksum byte.
  - If sum + checksum byte == 8'h00 -> DONE; else -> ERR.
  - The sum clears on each start.
- When undefined: no CHK state and no sum register. Transitions listed as "(or CHK)" go straight to DONE.

Test Plan:
- Reset, no start -> core_rst_n=0, byte_ready=0, busy=0, all outputs 0 for 20 cycles.
- start, then bytes 02 00 | 13 05 10 00 | 6F 00 00 00, byte_valid held high -> two writes: addr 0 data 0x00100513, addr 1 data 0x0000006F. imem_we is high exactly 2 cycles. done=1, core_rst_n=1 the cycle after the second write.
- Same image with byte_valid toggled randomly (50%) -> identical writes and no duplicated or dropped bytes. byte_ready=0 during each WRITE cycle.
- ADDR_W=4, header 11 00 (N=17) -> err=1, no imem_we, core_rst_n=0. A following start with header 00 00 -> done=1 (with checksum enabled, send byte 00).
- start mid-load and again in DONE: mid-load start ignored; start in DONE drops core_rst_n next cycle and the reload overwrites addr 0.
- IMEM_BOOT_CHECKSUM_EN, image 01 00 | 01 02 03 04 plus checksum F6 -> done. With checksum F5 -> err=1, core_rst_n=0 (the write to addr 0 still occurred).
